// File: rtl/lsu_sequencer.sv
// lsu_sequencer
//
// Load/store/fetch sequencer between the core control FSM and the SPI memory
// controller. Accepts one request at a time, classifies it (illegal width,
// misalignment), runs a level start/done handshake with the controller for
// legal accesses, and returns a one-cycle response with extended load data
// and an error cause.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   - WAIT is aborted after TIMEOUT_CYCLES cycles without mem_done
//               (cause 3).
//   undefined - WAIT persists until mem_done; no timeout counter exists.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid       core presents a request (sampled only while req_ready)
//   req_ready       high only in IDLE
//   req_is_fetch    instruction fetch (treated as LW, func3 ignored)
//   req_is_store    store (ignored for fetches)
//   req_func3       RISC-V width code
//   req_addr        byte address
//   req_wdata       store data, LSB-aligned
//   rsp_valid       one-cycle response pulse
//   rsp_rdata       extended load data; 0 for stores and errors
//   rsp_cause       0 ok, 1 misaligned, 2 illegal func3, 3 timeout
//   mem_start       level request to the controller
//   mem_write       1 = write cycle
//   mem_addr        word-aligned address
//   mem_wdata       lane-replicated store data
//   mem_wstrb       byte lane enables (0 on reads)
//   mem_rdata       controller read word
//   mem_done        controller completion level (ignored outside WAIT)
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request, req_ready high
// WAIT   | memory access in flight, mem_start held high
// RESP   | rsp_valid high for this single cycle, then back to IDLE

module lsu_sequencer #(
    parameter int ADDR_W         = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_fetch,
    input  logic              req_is_store,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_cause,
    output logic              mem_start,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_done
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("lsu_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_OK      = 2'd0;
    localparam logic [1:0] CAUSE_MISALGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
`ifdef LSU_TIMEOUT_EN
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;
    localparam int         CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t              state_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic [1:0]          rsp_cause_q;
    logic                mem_start_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_wstrb_q;
    logic [2:0]          func3_q;
    logic [1:0]          lane_q;
`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0]    wait_cnt_q;
`endif

    // Request classification and store lane formatting, from the live request.
    logic                is_store_d;
    logic [2:0]          func3_d;
    logic                illegal_d;
    logic                misaligned_d;
    logic [31:0]         wdata_d;
    logic [3:0]          wstrb_d;

    always_comb begin
        is_store_d   = req_is_store & ~req_is_fetch;
        func3_d      = req_is_fetch ? F3_LW : req_func3;
        illegal_d    = 1'b0;
        misaligned_d = 1'b0;
        wdata_d      = 32'h0;
        wstrb_d      = 4'h0;

        if (is_store_d) begin
            illegal_d = (func3_d > 3'd2);
        end else begin
            illegal_d = (func3_d == 3'd3) || (func3_d >= 3'd6);
        end

        // func3[1:0] encodes the size for every legal code.
        case (func3_d[1:0])
            2'b01:   misaligned_d = req_addr[0];
            2'b10:   misaligned_d = |req_addr[1:0];
            default: misaligned_d = 1'b0;
        endcase

        if (is_store_d) begin
            case (func3_d[1:0])
                2'b00: begin
                    wdata_d = {4{req_wdata[7:0]}};
                    wstrb_d = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    wdata_d = {2{req_wdata[15:0]}};
                    wstrb_d = 4'b0011 << req_addr[1:0];
                end
                default: begin
                    wdata_d = req_wdata;
                    wstrb_d = 4'hF;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the latched lane/width.
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_data_d;

    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (func3_q)
            F3_LB:   load_data_d = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data_d = {24'h0, byte_sel};
            F3_LH:   load_data_d = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data_d = {16'h0, half_sel};
            default: load_data_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_cause_q <= CAUSE_OK;
            mem_start_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            func3_q     <= 3'b000;
            lane_q      <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        func3_q     <= func3_d;
                        lane_q      <= req_addr[1:0];
                        if (illegal_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_cause_q <= CAUSE_ILLEGAL;
                        end else if (misaligned_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_cause_q <= CAUSE_MISALGN;
                        end else begin
                            state_q     <= S_WAIT;
                            mem_start_q <= 1'b1;
                            mem_write_q <= is_store_d;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_wstrb_q <= wstrb_d;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt_q  <= '0;
`endif
                        end
                    end
                end

                S_WAIT: begin
                    if (mem_done) begin
                        state_q     <= S_RESP;
                        mem_start_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_write_q ? 32'h0 : load_data_d;
                        rsp_cause_q <= CAUSE_OK;
                    end
`ifdef LSU_TIMEOUT_EN
                    // Done on the final cycle still wins over the abort.
                    else if (wait_cnt_q == CNT_LAST) begin
                        state_q     <= S_RESP;
                        mem_start_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                        rsp_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_cause_q <= CAUSE_OK;
                end

                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    mem_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_cause = rsp_cause_q;
    assign mem_start = mem_start_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Parametrised load/store/fetch sequencer between the RV32E core control FSM and the SPI memory controller. It accepts one memory request at a time from the core and drives the controller's level start/done handshake. It handles byte/halfword/word loads with sign or zero extension, byte/halfword/word stores with lane strobes, and misalignment and illegal-width checks. It returns a single-cycle response with an error cause.

## Interface
Parameters:
- ADDR_W, 24, byte-address width toward memory
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (only with LSU_TIMEOUT_EN); must be >= 1

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents request
- req_ready  out  1  high only in IDLE
- req_is_fetch  in  1  instruction fetch; func3 ignored, treated as LW
- req_is_store  in  1  store (ignored when req_is_fetch=1)
- req_func3  in  3  RISC-V width code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data / fetched instruction; 0 for stores and errors
- rsp_cause  out  2  0 ok, 1 misaligned, 2 illegal func3, 3 timeout
- mem_start  out  1  level request to controller
- mem_write  out  1  1 = write cycle
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte lane enables (0 on reads)
- mem_rdata  in  32  controller read word
- mem_done  in  1  controller completion level

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and classify it:
  - Illegal func3 -> RESP, cause 2. Loads allow 0,1,2,4,5; stores allow 0,1,2.
  - Otherwise misaligned -> RESP, cause 1. Halfword with addr[0]=1 is misaligned; word/fetch with addr[1:0]!=0 is misaligned.
  - Otherwise -> WAIT with mem_start<=1.
  - An illegal func3 takes priority over misalignment.
- WAIT: mem_start held high.
  - On mem_done=1: mem_start<=0, capture the lane-extracted result, -> RESP with cause 0.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. There is no backpressure.
- Load extraction uses lane = addr[1:0]:
  - LB/LBU take byte[lane], sign-/zero-extended.
  - LH/LHU take the half at lane[1], sign-/zero-extended.
  - LW/fetch take the full word.
- Store lanes:
  - SB: wstrb = 1<<lane, wdata = byte replicated x4.
  - SH: wstrb = 4'b0011<<lane, wdata = half replicated x2.
  - SW: wstrb = 4'hF.
- mem_addr = {req_addr[ADDR_W-1:2], 2'b00}. mem_addr, mem_write, mem_wdata and mem_wstrb are stable for the whole of WAIT.
- mem_done is ignored outside WAIT.
- All outputs reset to 0, except req_ready, which is 1 after reset (state IDLE).
- Reset asserted mid-operation returns the block to IDLE the next edge. mem_start drops and no response is emitted.

## Timing
- Error path: request accepted at edge T; rsp_valid is high in cycle T+1.
- Memory path: request accepted at edge T; mem_start is high from T+1. mem_done is sampled high at edge D; mem_start is low and rsp_valid is high in cycle D+1.
- Minimum memory latency: mem_done high in the first WAIT cycle gives rsp_valid two cycles after acceptance.
- mem_start is guaranteed low for at least one cycle (RESP) between consecutive accesses.
- req_ready is low from the cycle after acceptance until IDLE is re-entered. A new request may be accepted in the cycle right after rsp_valid.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT.
  - If mem_done has not been seen by the end of the TIMEOUT_CYCLES-th WAIT cycle, the block drops mem_start and goes to RESP with cause 3 and rdata 0.
  - If mem_done occurs on that same final cycle, done wins and cause is 0.
- LSU_TIMEOUT_EN undefined: WAIT persists indefinitely, cause 3 is never produced, and no counter logic is present.

## Test plan
- LW at 0x000010, mem_rdata=0xDEADBEEF, mem_done after 5 cycles -> mem_addr=0x000010, mem_write=0; rsp_rdata=0xDEADBEEF, cause 0; rsp_valid one cycle after done.
- LB at 0x000013 and LBU at 0x000013, mem_rdata=0x80FF1234 -> rsp_rdata=0xFFFFFF80 and 0x00000080; LH at 0x000012 -> 0xFFFF80FF.
- SB at 0x000021 with wdata=0x000000A5 -> mem_addr=0x000020, mem_wstrb=4'b0010, mem_wdata=0xA5A5A5A5, mem_write=1; SH at 0x000022 with wdata=0x1234 -> mem_wstrb=4'b1100.
- LW at 0x000002 -> cause 1, mem_start never rises; load func3=3 at 0x000002 -> cause 2; SW func3=2 aligned passes.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, mem_done held low -> mem_start high for exactly 4 cycles, then rsp_valid with cause 3; repeat with mem_done on the 4th cycle -> cause 0.
- rst pulsed during WAIT -> next cycle mem_start=0, req_ready=1, no rsp_valid; a subsequent fetch at 0x000000 completes normally.
